// File: rtl/token_ring_injector_pkg.sv
// Shared types for the token ring injector and the link stages that carry its tokens.
package token_ring_injector_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SUM_W  = 48;
    localparam int unsigned ERR_W  = 16;
    localparam int unsigned SEQ_W  = 16;
    localparam int unsigned TMO_W  = 21;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_INJECT = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic              wen;
        logic [DATA_W-1:0] token;
        logic [DATA_W-1:0] clk_cnt;
        logic [DATA_W-1:0] id;
    } tok_t;

    // Round-trip time from a timestamp; modular so it stays correct across counter wrap.
    function automatic logic [DATA_W-1:0] rtt_of(input logic [DATA_W-1:0] now,
                                                 input logic [DATA_W-1:0] stamp);
        return now - stamp;
    endfunction

endpackage

// File: rtl/token_ring_injector_if.sv
// One hop of the token ring: a single token payload with its valid strobe.
interface token_ring_injector_if;
    import token_ring_injector_pkg::*;

    tok_t tok;

    modport master (output tok);
    modport slave  (input  tok);

endinterface

// File: rtl/rtt_stats.sv
// Round-trip statistics: min/max, saturating sum and saturating error count.
module rtt_stats
    import token_ring_injector_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              clear,
    input  logic              upd,
    input  logic [DATA_W-1:0] rtt,
    input  logic [1:0]        err_add,
    output logic [DATA_W-1:0] rtt_min,
    output logic [DATA_W-1:0] rtt_max,
    output logic [SUM_W-1:0]  rtt_sum,
    output logic [ERR_W-1:0]  err_cnt
);

    localparam int unsigned SUM_XW = SUM_W + 1;
    localparam int unsigned ERR_XW = ERR_W + 1;

    logic [SUM_XW-1:0] sum_x_c;
    logic [ERR_XW-1:0] err_x_c;
    logic [SUM_W-1:0]  sum_sat_c;
    logic [ERR_W-1:0]  err_sat_c;

    // One extra bit of headroom detects overflow; clamp to all-ones instead of wrapping.
    always_comb begin
        sum_x_c   = {1'b0, rtt_sum} + SUM_XW'(rtt);
        err_x_c   = {1'b0, err_cnt} + ERR_XW'(err_add);
        sum_sat_c = sum_x_c[SUM_XW-1] ? '1 : sum_x_c[SUM_W-1:0];
        err_sat_c = err_x_c[ERR_XW-1] ? '1 : err_x_c[ERR_W-1:0];
    end

    // Accumulators; clear restores the empty-run values.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rtt_min <= '1;
            rtt_max <= '0;
            rtt_sum <= '0;
            err_cnt <= '0;
        end else if (clear) begin
            rtt_min <= '1;
            rtt_max <= '0;
            rtt_sum <= '0;
            err_cnt <= '0;
        end else begin
            if (upd) begin
                if (rtt < rtt_min) rtt_min <= rtt;
                if (rtt > rtt_max) rtt_max <= rtt;
                rtt_sum <= sum_sat_c;
            end
            err_cnt <= err_sat_c;
        end
    end

endmodule

// File: rtl/token_ring_injector.sv
// Injects numbered, timestamped tokens into a ring and measures their round-trip time.
module token_ring_injector
    import token_ring_injector_pkg::*;
#(
    parameter logic [31:0] ID       = 32'd0,
    parameter int unsigned N_TOKENS = 16,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    token_ring_injector_if.master o_link,
    token_ring_injector_if.slave  i_link,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_benchmark_event,
    output logic [DATA_W-1:0]     o_rtt_min,
    output logic [DATA_W-1:0]     o_rtt_max,
    output logic [SUM_W-1:0]      o_rtt_sum,
    output logic [ERR_W-1:0]      o_err_cnt
);

    localparam int unsigned SEQ_XW = SEQ_W + 1;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] cnt_q;
    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    tok_t              tx_q, tx_d, rx_c;
    logic              busy_q, busy_d, done_q, done_d, event_q, event_d;
    logic              match_c, mismatch_c, timeout_c, clear_c, last_c;
    logic [1:0]        err_add_c;
    logic [DATA_W-1:0] rtt_c;

    assign rx_c              = i_link.tok;
    assign o_link.tok        = tx_q;
    assign o_busy            = busy_q;
    assign o_done            = done_q;
    assign o_benchmark_event = event_q;
    assign rtt_c             = rtt_of(cnt_q, rx_c.clk_cnt);
    assign last_c            = (SEQ_XW'(seq_q) + SEQ_XW'(1)) == SEQ_XW'(N_TOKENS);

    // Free-running timestamp counter.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) cnt_q <= '0;
        else         cnt_q <= cnt_q + DATA_W'(1);
    end

    // FSM state and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            tmo_q   <= '0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            tmo_q   <= tmo_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            event_q <= event_d;
        end
    end

    // Next state; outputs are computed from the next state so o_wen lines up with INJECT.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        tmo_d      = tmo_q;
        tx_d       = tx_q;
        tx_d.wen   = 1'b0;
        clear_c    = 1'b0;
        match_c    = 1'b0;
        mismatch_c = 1'b0;
        timeout_c  = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        event_d    = 1'b0;
        err_add_c  = 2'd0;

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    clear_c = 1'b1;
                    seq_d   = '0;
                    state_d = S_INJECT;
                end
            end
            S_INJECT: begin
                tmo_d   = TMO_W'(TIMEOUT);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                match_c    = rx_c.wen && (rx_c.id == ID) && (rx_c.token == DATA_W'(seq_q));
                mismatch_c = rx_c.wen && !match_c;
                timeout_c  = !match_c && (tmo_q == '0);
                if (match_c || timeout_c) begin
                    seq_d   = seq_q + SEQ_W'(1);
                    state_d = last_c ? S_DONE : S_INJECT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_INJECT) begin
            tx_d.wen     = 1'b1;
            tx_d.token   = DATA_W'(seq_d);
            tx_d.clk_cnt = cnt_q + DATA_W'(1);
            tx_d.id      = ID;
        end

        busy_d    = (state_d == S_INJECT) || (state_d == S_WAIT);
        done_d    = (state_d == S_DONE);
        event_d   = done_d && (state_q != S_DONE);
        err_add_c = {1'b0, mismatch_c} + {1'b0, timeout_c};
    end

    rtt_stats u_rtt_stats (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .clear   (clear_c),
        .upd     (match_c),
        .rtt     (rtt_c),
        .err_add (err_add_c),
        .rtt_min (o_rtt_min),
        .rtt_max (o_rtt_max),
        .rtt_sum (o_rtt_sum),
        .err_cnt (o_err_cnt)
    );

endmodule

// File: doc/token_ring_injector.md
TOKEN_RING_INJECTOR -- requirements
Module: token_ring_injector

Interface
REQ-001 Parameter ID, default 0: value driven on o_id and expected back on i_id.
REQ-002 Parameter N_TOKENS, default 16: tokens per benchmark run, 1..65535.
REQ-003 Parameter TIMEOUT, default 1024: cycles to wait for a token's return, 1..2^20.
REQ-004 Clock and reset are decided: one clock, i_clk; asynchronous active-low reset, i_rstn.
REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 i_rstn  in  1  asynchronous, active-low reset.
REQ-007 i_start  in  1  single-cycle pulse that begins a run.
REQ-008 o_wen  out  1  token-valid strobe into the first link stage.
REQ-009 o_token  out  32  sequence number of the injected token.
REQ-010 o_clk_cnt  out  32  cycle timestamp at injection.
REQ-011 o_id  out  32  ID of the originating injector.
REQ-012 i_wen  in  1  return strobe from the last link stage.
REQ-013 i_token  in  32  returned sequence number.
REQ-014 i_clk_cnt  in  32  returned timestamp.
REQ-015 i_id  in  32  returned originator ID.
REQ-016 o_busy  out  1  high while a run is in progress.
REQ-017 o_done  out  1  high in DONE.
REQ-018 o_benchmark_event  out  1  one-cycle pulse on entry to DONE.
REQ-019 o_rtt_min  out  32  minimum round-trip time of the run.
REQ-020 o_rtt_max  out  32  maximum round-trip time of the run.
REQ-021 o_rtt_sum  out  48  sum of the round-trip times of the run.
REQ-022 o_err_cnt  out  16  count of timeouts plus mismatched returns.

Function
REQ-023 A 32-bit free-running cycle counter shall increment every cycle and wrap modulo 2^32.
REQ-024 The FSM states shall be IDLE, INJECT, WAIT, DONE.
REQ-025 In IDLE or DONE, i_start shall clear the stats, set seq=0, and move to INJECT.
REQ-026 In INJECT, o_wen shall be 1 for exactly one cycle, with o_token=seq, o_clk_cnt=counter, o_id=ID; the FSM then moves to WAIT and loads the timeout counter with TIMEOUT.
REQ-027 Outside INJECT, o_wen shall be 0 and o_token, o_clk_cnt and o_id shall hold their last values.
REQ-028 In WAIT, a match is i_wen=1 and i_id=ID and i_token=seq; RTT = counter - i_clk_cnt, modulo 2^32.
REQ-029 On a match, the block shall update min, max and sum in the same cycle; min starts at 0xFFFFFFFF and max starts at 0.
REQ-030 In WAIT, i_wen=1 without a match shall increment o_err_cnt; the block shall keep waiting.
REQ-031 A timeout counter reaching 0 in WAIT shall increment o_err_cnt and abandon the token.
REQ-032 After a match or a timeout, seq increments; if seq+1 == N_TOKENS the FSM goes to DONE, otherwise to INJECT on the next cycle.
REQ-033 A match and a timeout in the same cycle shall count as a match.
REQ-034 o_err_cnt and o_rtt_sum shall saturate, never wrap.
REQ-035 i_start in INJECT or WAIT shall be ignored.
REQ-036 i_wen outside WAIT shall be ignored, with no error counted.
REQ-037 o_benchmark_event shall pulse for one cycle on entry to DONE; DONE holds the stats until the next i_start.

Reset
REQ-038 While i_rstn=0, the FSM shall be IDLE and every output 0 except o_rtt_min=0xFFFFFFFF; the cycle counter, seq and timeout counter shall be 0.
REQ-039 Reset asserted mid-run shall abort immediately, with no event pulse.
REQ-040 After release, the block shall wait for i_start.

Structure
REQ-041 The FSM state enum and the token payload struct (wen, token, clk_cnt, id) shall live in a shared package that link stages also import.
REQ-042 One sub-module, rtt_stats, shall hold min/max/saturating-sum/error accumulation.
REQ-043 The block shall contain no DPI calls; it is pure synthesizable RTL.

Verification
REQ-044 N_TOKENS=4, loopback with a 5-cycle delay, i_start -> four o_wen pulses, min=max=5, sum=20, err=0, one event pulse.
REQ-045 Ring drops token 2, TIMEOUT=8 -> err=1, sum counts three tokens, DONE reached.
REQ-046 Return with i_id=ID+1 in WAIT, then the correct return -> err=1, correct RTT recorded.
REQ-047 Injection when the counter is 0xFFFFFFFE, delay 5 -> RTT=5 across the wrap.
REQ-048 Reset mid-WAIT -> all outputs at reset values, no event; a later i_start runs cleanly.
REQ-049 i_start during WAIT -> ignored; seq and stats unchanged.
